// File: rtl/lampfpu_exp_mul_arb.sv
// Round-robin arbiter that shares one single-cycle-latency bfloat16 multiplier
// among N_REQ requesters of the exponential unit. It tracks the one operation in
// flight and parks each result in a per-requester slot until it is consumed.
module lampfpu_exp_mul_arb #(
    parameter int N_REQ  = 4,
    parameter int OP_DW  = 50,
    parameter int RES_DW = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*OP_DW-1:0]   req_op_i,
    output logic                     mul_doMul_o,
    output logic [OP_DW-1:0]         mul_op_o,
    input  logic                     mul_valid_i,
    input  logic [RES_DW-1:0]        mul_res_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    input  logic [N_REQ-1:0]         rsp_ready_i,
    output logic [N_REQ*RES_DW-1:0]  rsp_res_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int TW = $clog2(N_REQ);

    logic [N_REQ-1:0]  r_pending;
    logic [N_REQ-1:0]  r_slot_vld;
    logic [RES_DW-1:0] r_slot_res [N_REQ];
    logic              r_inflight_vld;
    logic [TW-1:0]     r_inflight_tag;
    logic [TW-1:0]     r_ptr;
    logic              r_err;

    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_hs;
    logic              w_gnt_vld;
    logic [TW-1:0]     w_gnt_idx;
    logic [TW-1:0]     w_cand;
    logic [TW-1:0]     w_ptr_next;

    // Eligibility looks only at registered pending, so a requester cannot be
    // re-granted in the cycle of its own response handshake. Held off in reset.
    assign w_elig = req_valid_i & ~r_pending & {N_REQ{rst}};
    assign w_hs   = r_slot_vld & rsp_ready_i;

    // Round-robin search starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = TW'((int'(r_ptr) + k) % N_REQ);
            if (!w_gnt_vld && w_elig[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_ptr_next  = TW'((int'(w_gnt_idx) + 1) % N_REQ);
    assign mul_doMul_o = w_gnt_vld;
    assign mul_op_o    = w_gnt_vld ? req_op_i[w_gnt_idx*OP_DW +: OP_DW] : '0;
    assign rsp_valid_o = r_slot_vld;
    assign busy_o      = (|r_pending) | r_inflight_vld;
    assign err_o       = r_err;

    // Shared state: in-flight tracking, round-robin pointer, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight_vld <= 1'b0;
            r_inflight_tag <= '0;
            r_ptr          <= '0;
            r_err          <= 1'b0;
        end else begin
            r_inflight_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_inflight_tag <= w_gnt_idx;
                r_ptr          <= w_ptr_next;
            end
            // A result with nothing in flight, or a missing result, is a protocol error.
            if (mul_valid_i != r_inflight_vld) begin
                r_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
            assign req_ready_o[gi]                 = w_gnt_vld && (w_gnt_idx == TW'(gi));
            assign rsp_res_o[gi*RES_DW +: RES_DW]  = r_slot_res[gi];

            // Per-requester pending flag and result slot; a grant wins over clears.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pending[gi]  <= 1'b0;
                    r_slot_vld[gi] <= 1'b0;
                    r_slot_res[gi] <= '0;
                end else begin
                    if (w_hs[gi]) begin
                        r_slot_vld[gi] <= 1'b0;
                        r_pending[gi]  <= 1'b0;
                    end
                    if (r_inflight_vld && (r_inflight_tag == TW'(gi))) begin
                        if (mul_valid_i) begin
                            r_slot_vld[gi] <= 1'b1;
                            r_slot_res[gi] <= mul_res_i;
                        end else begin
                            // Lost result: free the requester so it can retry.
                            r_pending[gi] <= 1'b0;
                        end
                    end
                    if (w_gnt_vld && (w_gnt_idx == TW'(gi))) begin
                        r_pending[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/lampfpu_exp_mul_arb.md
# lampfpu_exp_mul_arb

Round-robin arbiter and sequencer that shares one bfloat16 multiplier stage among `N_REQ` requesters inside the exponential unit, e.g. range reduction, polynomial evaluation and reconstruction. The multiplier stage is the single-register-latency EXP mul with `doMul`/`valid`.

- Each requester has a valid/ready request channel and a valid/ready response channel.
- The arbiter issues at most one multiply per cycle.
- It tracks the single in-flight operation and parks each result in a per-requester slot until the requester consumes it.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `OP_DW`, 50: packed operand-pair width, `{op1, op2}`. Each operand is `{s, extShF[7:0], extE[8:0], nlz[2:0], isZ, isInf, isSNAN, isQNAN}`, 25 bits.
- `RES_DW`, 24: packed result width, `{s, e[7:0], f[11:0], isOverflow, isUnderflow, isToRound}`.

Ports:
- `clk`, in, 1: the single clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `req_valid_i`, in, N_REQ: requester i has an operand pair.
- `req_ready_o`, out, N_REQ: one-hot grant, combinational.
- `req_op_i`, in, N_REQ*OP_DW: operand pairs; requester i at `[i*OP_DW +: OP_DW]`.
- `mul_doMul_o`, out, 1: issue strobe to the multiplier.
- `mul_op_o`, out, OP_DW: operand pair of the granted requester; all zeros when there is no grant.
- `mul_valid_i`, in, 1: multiplier result valid.
- `mul_res_i`, in, RES_DW: multiplier result bundle.
- `rsp_valid_o`, out, N_REQ: result slot i full.
- `rsp_ready_i`, in, N_REQ: requester i consumes its result.
- `rsp_res_o`, out, N_REQ*RES_DW: slot contents, packed like `req_op_i`.
- `busy_o`, out, 1: any slot pending, or an operation in flight.
- `err_o`, out, 1: sticky protocol error.

## Operation
State:
- `pending[N_REQ]`: set on grant, cleared on response handshake.
- `inflight_vld` and `inflight_tag[$clog2(N_REQ)]`.
- `ptr[$clog2(N_REQ)]`: round-robin pointer.
- `slot_vld[N_REQ]` and `slot_res[N_REQ][RES_DW]`.
- `err`.

Grant rules:
- Eligible(i) = `req_valid_i[i] & ~pending[i]`. Uses registered `pending` only, so a requester is never re-granted in the same cycle as its own response handshake.
- Grant the first eligible index searching ptr, ptr+1, …, wrapping modulo N_REQ.
- On a grant to g: `req_ready_o[g]=1`, `mul_doMul_o=1`, `mul_op_o=req_op_i[g]`. At the clock edge: `pending[g]<=1`, `inflight_vld<=1`, `inflight_tag<=g`, `ptr<=(g+1) mod N_REQ`.
- No grant: `ptr` holds, `inflight_vld<=0`.

Result capture (multiplier latency is fixed at 1 cycle):
- `mul_valid_i` with `inflight_vld=1`: `slot_res[tag]<=mul_res_i`, `slot_vld[tag]<=1`.
- `mul_valid_i` with `inflight_vld=0`: result discarded, `err<=1`.
- `inflight_vld=1` without `mul_valid_i`: `err<=1`, and `pending[tag]` is cleared (requester may retry).

Response handshake:
- `rsp_valid_o=slot_vld`; `rsp_valid_o[i]&rsp_ready_i[i]` clears `slot_vld[i]` and `pending[i]`.
- Each slot holds its value until consumed; other requesters are unaffected by a stalled consumer.
- `busy_o = |pending | inflight_vld`. `err_o = err`, cleared only by reset.

## Timing
- Reset (`rst`=0, asynchronous): `pending`, `slot_vld`, `inflight_vld`, `ptr`, `err` and `slot_res` all clear. Outputs during and after reset: `req_ready_o=0`, `mul_doMul_o=0`, `mul_op_o=0`, `rsp_valid_o=0`, `rsp_res_o=0`, `busy_o=0`, `err_o=0`. Reset mid-operation drops the in-flight op silently; the multiplier is reset from the same net.
- Latency, request accepted in cycle c: `mul_valid_i` in c+1, `rsp_valid_o[i]` high in c+2.
- Re-issue for the same requester: earliest the cycle after its response handshake, so a requester with `rsp_ready_i` tied high issues every 3 cycles.
- Throughput: one issue per cycle across distinct requesters; with N_REQ≥3 and all ready, `mul_doMul_o` stays high continuously.
- Simultaneous capture for slot j and handshake on slot i≠j in the same cycle: both take effect.
- Fairness: a continuously requesting, eligible requester waits at most N_REQ-1 grants.

## Test plan
- Single op: req 2 valid from cycle 1, `rsp_ready_i` high → grant cycle 1, `rsp_valid_o[2]` cycle 3 with `rsp_res_o` slice equal to the mul output; `busy_o` low cycle 4.
- All 4 requesting continuously, ptr=0 → grants 0,1,2,3,0,… with `mul_doMul_o` never low after the first grant.
- Requester 1 holds `rsp_ready_i[1]=0` for 10 cycles → its slot value stays stable, requester 1 receives no further grants, and 0/2/3 keep being served round-robin.
- `mul_valid_i` pulsed with nothing in flight → result not stored anywhere, `err_o` rises next cycle and stays high.
- Reset asserted the cycle after a grant → all outputs 0 immediately. After release, the first grant goes to the lowest eligible index, since ptr=0.
